// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU instruction/data request ports and shared RAM port of mem_arbiter.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter, data priority with bounded instruction starvation.
module mem_arbiter #(
    parameter logic [3:0] ISTARVE = 4'd4
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IXFER, DXFER} state_t;

    state_t      state, next_state;
    logic [3:0]  streak;
    logic        op_w, err_q;
    logic [31:0] addr_q, store_q, iload_q, dload_q, rdata;
    logic        d_win, i_win, owner_req, done, fail;

    assign d_win = (bus.dREN | bus.dWEN) && !(bus.iREN && streak == ISTARVE);
    assign i_win = bus.iREN && !d_win;

    // ramstate[1] marks ACCESS or ERROR; a dropped request beats a same-cycle completion
    always_comb begin
        next_state = state;
        owner_req  = (state == IXFER) ? bus.iREN : (bus.dREN | bus.dWEN);
        done       = (state != IDLE) && owner_req && bus.ramstate[1];
        fail       = done && bus.ramstate[0];
        rdata      = fail ? 32'hBAD1_BAD1 : bus.ramload;
        next_state = (state == IDLE) ? (d_win ? DXFER : i_win ? IXFER : IDLE)
                   : (!owner_req || done) ? IDLE : state;
    end

    assign bus.iwait    = !(done && state == IXFER);
    assign bus.dwait    = !(done && state == DXFER);
    assign bus.iload    = (done && state == IXFER) ? rdata : iload_q;
    assign bus.dload    = (done && state == DXFER && !op_w) ? rdata : dload_q;
    assign bus.ramREN   = (state == IXFER) || (state == DXFER && !op_w);
    assign bus.ramWEN   = (state == DXFER) && op_w;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.err      = err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            streak  <= 4'd0;
            op_w    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            store_q <= 32'd0;
            iload_q <= 32'd0;
            dload_q <= 32'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && d_win) begin
                addr_q  <= bus.daddr;
                store_q <= bus.dstore;
                op_w    <= bus.dWEN;
                streak  <= bus.iREN ? (streak == ISTARVE ? streak : streak + 4'd1) : 4'd0;
            end else if (state == IDLE && i_win) begin
                addr_q <= bus.iaddr;
                op_w   <= 1'b0;
                streak <= 4'd0;
            end
            if (done && state == IXFER) iload_q <= rdata;
            if (done && state == DXFER && !op_w) dload_q <= rdata;
            if (fail) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    localparam int ISTARVE = 4;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    mem_arbiter_if bus();

    mem_arbiter #(.ISTARVE(4'd4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // model: who owns the RAM (0 none, 1 instruction, 2 data) and what was latched
    int          m_own, m_streak;
    logic [31:0] m_addr, m_store, m_iload, m_dload;
    logic        m_wr, m_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_streak = 0; m_addr = 0; m_store = 0;
        m_iload = 0; m_dload = 0; m_wr = 0; m_err = 0;
    endtask

    function automatic logic still_wanted();
        return (m_own == 1) ? bus.iREN : (bus.dREN | bus.dWEN);
    endfunction

    function automatic logic finishing();
        return m_own != 0 && still_wanted() && bus.ramstate >= 2'd2;
    endfunction

    function automatic logic [31:0] result_word();
        return (bus.ramstate == 2'd3) ? 32'hBAD1_BAD1 : bus.ramload;
    endfunction

    task automatic compare();
        logic f;
        f = finishing();
        chk("iwait", bus.iwait, !(f && m_own == 1));
        chk("dwait", bus.dwait, !(f && m_own == 2));
        chk("iload", bus.iload, (f && m_own == 1) ? result_word() : m_iload);
        chk("dload", bus.dload, (f && m_own == 2 && !m_wr) ? result_word() : m_dload);
        chk("ramREN", bus.ramREN, m_own == 1 || (m_own == 2 && !m_wr));
        chk("ramWEN", bus.ramWEN, m_own == 2 && m_wr);
        chk("ramaddr", bus.ramaddr, m_addr);
        chk("ramstore", bus.ramstore, m_store);
        chk("err", bus.err, m_err);
    endtask

    task automatic model_update();
        if (m_own == 0) begin
            if ((bus.dREN | bus.dWEN) && !(bus.iREN && m_streak == ISTARVE)) begin
                m_own = 2; m_addr = bus.daddr; m_store = bus.dstore; m_wr = bus.dWEN;
                m_streak = bus.iREN ? ((m_streak < ISTARVE) ? m_streak + 1 : ISTARVE) : 0;
            end else if (bus.iREN) begin
                m_own = 1; m_addr = bus.iaddr; m_wr = 0; m_streak = 0;
            end
        end else if (!still_wanted()) begin
            m_own = 0;
        end else if (bus.ramstate >= 2'd2) begin
            if (m_own == 1) m_iload = result_word();
            else if (!m_wr) m_dload = result_word();
            m_err = m_err | (bus.ramstate == 2'd3);
            m_own = 0;
        end
    endtask

    task automatic mid();
        #4;
        compare();
    endtask

    task automatic fin();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
        bus.ramload = 0; bus.ramstate = 2'd0;
    endtask

    int   exp_g[6] = '{2, 2, 2, 2, 1, 2};
    int   g[8];
    int   ng;
    logic prev;
    int   r;

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // reset state, quiet bus
        mid();
        chk("rst_iwait", bus.iwait, 1); chk("rst_dwait", bus.dwait, 1);
        chk("rst_iload", bus.iload, 0); chk("rst_dload", bus.dload, 0);
        chk("rst_ramaddr", bus.ramaddr, 0); chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_err", bus.err, 0);
        fin();
        for (int c = 0; c < 10; c++) begin
            mid();
            chk("quiet_strobes", {bus.ramREN, bus.ramWEN}, 0);
            fin();
        end

        // instruction read, ACCESS on third transfer cycle
        bus.iREN = 1; bus.iaddr = 32'h40;
        mid(); chk("i_c0_ramREN", bus.ramREN, 0); fin();
        mid(); chk("i_c1_ramREN", bus.ramREN, 1); chk("i_c1_addr", bus.ramaddr, 32'h40); chk("i_c1_iwait", bus.iwait, 1); fin();
        bus.ramstate = 2'd1;
        mid(); chk("i_c2_ramREN", bus.ramREN, 1); chk("i_c2_iwait", bus.iwait, 1); fin();
        bus.ramstate = 2'd2; bus.ramload = 32'h8C22_0004;
        mid(); chk("i_c3_iwait", bus.iwait, 0); chk("i_c3_iload", bus.iload, 32'h8C22_0004);
        chk("i_c3_dwait", bus.dwait, 1); chk("i_c3_addr", bus.ramaddr, 32'h40); fin();
        bus.iREN = 0; bus.ramstate = 2'd0; bus.ramload = 0;
        mid(); chk("i_c4_iwait", bus.iwait, 1); chk("i_c4_iload", bus.iload, 32'h8C22_0004); chk("i_c4_ramREN", bus.ramREN, 0); fin();

        // simultaneous data write and instruction read: D first, then I
        bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF; bus.iREN = 1; bus.iaddr = 32'h40;
        mid(); fin();
        bus.ramstate = 2'd2;
        mid(); chk("w_ramWEN", bus.ramWEN, 1); chk("w_ramREN", bus.ramREN, 0);
        chk("w_ramstore", bus.ramstore, 32'hDEAD_BEEF); chk("w_addr", bus.ramaddr, 32'h100);
        chk("w_dwait", bus.dwait, 0); chk("w_iwait", bus.iwait, 1); fin();
        bus.dWEN = 0; bus.ramstate = 2'd0;
        mid(); chk("w_gap_strobes", {bus.ramREN, bus.ramWEN}, 0); fin();
        bus.ramstate = 2'd2; bus.ramload = 32'h1234_5678;
        mid(); chk("w_i_ramREN", bus.ramREN, 1); chk("w_i_addr", bus.ramaddr, 32'h40); chk("w_i_iwait", bus.iwait, 0); fin();
        bus.iREN = 0; bus.ramstate = 2'd0;
        mid(); fin();

        // starvation bound: held iREN against continuous data reads
        bus.iREN = 1; bus.iaddr = 32'h40; bus.dREN = 1; bus.daddr = 32'h100;
        bus.ramstate = 2'd2; bus.ramload = 32'h1111_2222;
        ng = 0; prev = 0;
        for (int c = 0; c < 16; c++) begin
            mid();
            if ((bus.ramREN | bus.ramWEN) && !prev && ng < 8) begin
                g[ng] = (bus.ramaddr == 32'h40) ? 1 : 2;
                ng++;
            end
            prev = bus.ramREN | bus.ramWEN;
            fin();
        end
        for (int k = 0; k < 6; k++) chk($sformatf("grant%0d", k), (k < ng) ? g[k] : 0, exp_g[k]);
        idle_inputs();
        repeat (2) begin mid(); fin(); end

        // cancel during BUSY
        bus.dREN = 1; bus.daddr = 32'h200;
        mid(); fin();
        bus.ramstate = 2'd1;
        mid(); chk("c_ramREN", bus.ramREN, 1); fin();
        bus.dREN = 0;
        mid(); chk("c_dwait", bus.dwait, 1); fin();
        bus.ramstate = 2'd2; bus.ramload = 32'h5555_AAAA;
        mid(); chk("c_after_ramREN", bus.ramREN, 0); chk("c_after_dwait", bus.dwait, 1);
        chk("c_after_dload", bus.dload, 32'h1111_2222); fin();
        idle_inputs();

        // ERROR during instruction transfer, then reset mid data transfer
        bus.iREN = 1; bus.iaddr = 32'h80;
        mid(); fin();
        bus.ramstate = 2'd3;
        mid(); chk("e_iwait", bus.iwait, 0); chk("e_iload", bus.iload, 32'hBAD1_BAD1); chk("e_err_pre", bus.err, 0); fin();
        bus.iREN = 0; bus.ramstate = 2'd0;
        mid(); chk("e_err", bus.err, 1); chk("e_iwait_after", bus.iwait, 1); chk("e_iload_hold", bus.iload, 32'hBAD1_BAD1); fin();
        bus.dREN = 1; bus.daddr = 32'h300;
        mid(); fin();
        bus.ramstate = 2'd1;
        mid(); chk("e_d_ramREN", bus.ramREN, 1); chk("e_err_sticky", bus.err, 1);
        nRST = 1'b0;
        #1;
        chk("ar_err", bus.err, 0); chk("ar_ramREN", bus.ramREN, 0); chk("ar_ramWEN", bus.ramWEN, 0);
        chk("ar_iload", bus.iload, 0); chk("ar_ramaddr", bus.ramaddr, 0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        model_reset();
        idle_inputs();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.iREN = bus.iREN ? ($urandom_range(11, 0) != 0) : ($urandom_range(2, 0) == 0);
            bus.iaddr = $urandom;
            if ((bus.dREN | bus.dWEN) && $urandom_range(11, 0) == 0) begin
                bus.dREN = 0; bus.dWEN = 0;
            end else if (!(bus.dREN | bus.dWEN) && $urandom_range(2, 0) == 0) begin
                bus.dWEN = 1'($urandom_range(1, 0));
                bus.dREN = !bus.dWEN | 1'($urandom_range(1, 0));
            end
            bus.daddr = $urandom; bus.dstore = $urandom; bus.ramload = $urandom;
            r = $urandom_range(19, 0);
            bus.ramstate = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 18) ? 2'd2 : 2'd3;
            mid();
            fin();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
